// File: rtl/exe_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// exe_mem_pipe_reg: EXE->MEM pipeline register with 2-entry skid buffer,
// flush, and forwarding taps.  Revision: 1.0
// ============================================================================
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] ST_val_out,
    output logic [DEST_W-1:0] Dest_out,
    output logic [1:0]        occupancy,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st;
        logic [DEST_W-1:0] dest;
    } beat_t;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;

    beat_t in_beat;
    logic  acc;
    logic  deq;

    assign in_beat = '{wb:   WB_en_in,
                       mr:   MEM_R_EN_in,
                       mw:   MEM_W_EN_in,
                       alu:  ALU_result_in,
                       st:   ST_val_in,
                       dest: Dest_in};

    // in_ready comes straight off the skid flop so MEM stalls never reach EXE combinationally.
    assign in_ready = ~skid_valid_q;
    assign acc      = in_valid & in_ready;
    assign deq      = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d.wb    = 1'b0;
            main_d.mr    = 1'b0;
            main_d.mw    = 1'b0;
            skid_d.wb    = 1'b0;
            skid_d.mr    = 1'b0;
            skid_d.mw    = 1'b0;
        end else if (!main_valid_q) begin
            if (acc) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (deq && acc) begin
                main_d = in_beat;
            end else if (deq) begin
                main_valid_d = 1'b0;
            end else if (acc) begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (deq) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Control bits are masked so a bubble can never write back or touch memory.
    assign out_valid      = main_valid_q;
    assign WB_en_out      = main_q.wb & main_valid_q;
    assign MEM_R_EN_out   = main_q.mr & main_valid_q;
    assign MEM_W_EN_out   = main_q.mw & main_valid_q;
    assign ALU_result_out = main_q.alu;
    assign ST_val_out     = main_q.st;
    assign Dest_out       = main_q.dest;

    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign fwd_valid = WB_en_out;
    assign fwd_dest  = main_q.dest;
    assign fwd_data  = main_q.alu;

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// tb_exe_mem_pipe_reg: scoreboard bench for exe_mem_pipe_reg.
// Revision: 1.0
// ============================================================================
module tb_exe_mem_pipe_reg;

    localparam int DW  = 32;
    localparam int DSW = 4;

    typedef struct packed {
        logic           wb;
        logic           mr;
        logic           mw;
        logic [DW-1:0]  alu;
        logic [DW-1:0]  st;
        logic [DSW-1:0] dest;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic           WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [DW-1:0]  ALU_result_in, ST_val_in;
    logic [DSW-1:0] Dest_in;
    logic           out_valid;
    logic           out_ready;
    logic           WB_en_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [DW-1:0]  ALU_result_out, ST_val_out;
    logic [DSW-1:0] Dest_out;
    logic [1:0]     occupancy;
    logic           fwd_valid;
    logic [DSW-1:0] fwd_dest;
    logic [DW-1:0]  fwd_data;

    always #5 clk = ~clk;

    exe_mem_pipe_reg #(.DATA_W(DW), .DEST_W(DSW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WB_en_out(WB_en_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .ALU_result_out(ALU_result_out), .ST_val_out(ST_val_out), .Dest_out(Dest_out),
        .occupancy(occupancy),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] alu, input logic [DSW-1:0] dest,
                                 input logic wb, input logic mr, input logic mw,
                                 input logic [DW-1:0] st);
        beat_t b;
        b.wb = wb; b.mr = mr; b.mw = mw; b.alu = alu; b.st = st; b.dest = dest;
        return b;
    endfunction

    task automatic check_outputs();
        beat_t b;
        check("in_ready",  {63'd0, in_ready},  {63'd0, sb.size() < 2});
        check("occupancy", {62'd0, occupancy}, 64'(sb.size()));
        check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            b = sb[0];
            check("alu_out",   64'(ALU_result_out), 64'(b.alu));
            check("st_out",    64'(ST_val_out),     64'(b.st));
            check("dest_out",  64'(Dest_out),       64'(b.dest));
            check("wb_out",    64'(WB_en_out),      64'(b.wb));
            check("mr_out",    64'(MEM_R_EN_out),   64'(b.mr));
            check("mw_out",    64'(MEM_W_EN_out),   64'(b.mw));
            check("fwd_valid", 64'(fwd_valid),      64'(b.wb));
            check("fwd_dest",  64'(fwd_dest),       64'(b.dest));
            check("fwd_data",  64'(fwd_data),       64'(b.alu));
        end else begin
            check("bubble_ctrl", {61'd0, WB_en_out, MEM_R_EN_out, MEM_W_EN_out}, 64'd0);
            check("bubble_fwd",  64'(fwd_valid), 64'd0);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic v, input beat_t b, input logic rdy, input logic fl);
        logic acc, deq;
        in_valid      = v;
        WB_en_in      = b.wb;
        MEM_R_EN_in   = b.mr;
        MEM_W_EN_in   = b.mw;
        ALU_result_in = b.alu;
        ST_val_in     = b.st;
        Dest_in       = b.dest;
        out_ready     = rdy;
        flush         = fl;
        @(negedge clk);
        check_outputs();
        acc = v && (sb.size() < 2);
        deq = (sb.size() != 0) && rdy;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (deq) void'(sb.pop_front());
            if (acc) sb.push_back(b);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ctrl"},  {61'd0, WB_en_out, MEM_R_EN_out, MEM_W_EN_out}, 64'd0);
        check({tag, "_data"},  {ALU_result_out, ST_val_out}, 64'd0);
        check({tag, "_dest"},  64'(Dest_out), 64'd0);
        check({tag, "_occ"},   64'(occupancy), 64'd0);
        check({tag, "_fwd"},   {fwd_valid, fwd_dest, fwd_data}, 64'd0);
        check({tag, "_rdy"},   64'(in_ready), 64'd1);
    endtask

    beat_t idle;

    initial begin
        idle          = mk(32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        WB_en_in      = 1'b0;
        MEM_R_EN_in   = 1'b0;
        MEM_W_EN_in   = 1'b0;
        ALU_result_in = '0;
        ST_val_in     = '0;
        Dest_in       = '0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at full rate
        step(1, mk(32'h11, 4'd1, 1, 0, 0, 32'h1001), 1, 0);
        step(1, mk(32'h22, 4'd2, 0, 1, 0, 32'h1002), 1, 0);
        step(1, mk(32'h33, 4'd3, 1, 0, 1, 32'h1003), 1, 0);
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);

        // Backpressure fills main and skid; 0xC is refused while full
        step(1, mk(32'hA, 4'd5, 1, 0, 0, 32'hAAAA), 0, 0);
        step(1, mk(32'hB, 4'd6, 0, 0, 1, 32'hBBBB), 0, 0);
        step(1, mk(32'hC, 4'd7, 1, 1, 0, 32'hCCCC), 0, 0);
        step(1, mk(32'hC, 4'd7, 1, 1, 0, 32'hCCCC), 0, 0);
        // Drain: A, B, then C
        step(1, mk(32'hC, 4'd7, 1, 1, 0, 32'hCCCC), 1, 0);
        step(1, mk(32'hC, 4'd7, 1, 1, 0, 32'hCCCC), 1, 0);
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);

        // Flush from the full state with a concurrent incoming beat
        step(1, mk(32'hD1, 4'd8, 1, 1, 1, 32'h1), 0, 0);
        step(1, mk(32'hD2, 4'd9, 1, 1, 1, 32'h2), 0, 0);
        step(1, mk(32'hEE, 4'd10, 1, 1, 1, 32'h3), 0, 1);
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);

        // Asynchronous reset mid-cycle while full
        step(1, mk(32'hF1, 4'd11, 1, 0, 1, 32'h4), 0, 0);
        step(1, mk(32'hF2, 4'd12, 1, 1, 0, 32'h5), 0, 0);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        #1 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sb.delete();
        #1 rst = 1'b0;
        step(1, mk(32'h55, 4'd13, 1, 0, 0, 32'h55), 1, 0);
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            beat_t b;
            b = mk($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            step(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0));
        end
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);
        step(0, idle, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised EXE->MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer (main slot + skid slot), synchronous flush, and forwarding taps. It carries the EXE-stage result bundle (ALU result, store value, destination register, WB/MEM control bits) to the MEM stage. It lets the MEM stage stall without a combinational ready path back into EXE. It also lets the hazard unit kill in-flight instructions.

Parameters:
DATA_W, 32, width of ALU result and store value
DEST_W, 4, width of destination register index

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held and incoming beats
in_valid  input  1  EXE presents a beat
in_ready  output  1  register can accept a beat; registered, equals NOT skid_valid
WB_en_in, MEM_R_EN_in, MEM_W_EN_in  input  1 each  control bits
ALU_result_in  input  DATA_W  ALU result
ST_val_in  input  DATA_W  store data
Dest_in  input  DEST_W  destination register
out_valid  output  1  main slot holds a beat
out_ready  input  1  MEM stage accepts the beat
WB_en_out, MEM_R_EN_out, MEM_W_EN_out  output  1 each  main-slot control bits ANDed with out_valid
ALU_result_out, ST_val_out  output  DATA_W  main-slot data
Dest_out  output  DEST_W  main-slot destination
occupancy  output  2  number of held beats, 0..2
fwd_valid  output  1  out_valid AND main WB_en (forwarding candidate)
fwd_dest  output  DEST_W  Dest_out
fwd_data  output  DATA_W  ALU_result_out

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, all stored fields=0.
  - Outputs during reset: out_valid=0, all *_out=0, occupancy=0, fwd_valid=0, in_ready=1.
- Definitions:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
  - Invariant: skid_valid implies main_valid.
- Latency: a beat accepted at edge N appears on the outputs after edge N. One-cycle latency when the register is not stalled.
- Transitions per edge (flush=0):
  - main empty, acc: beat -> main.
  - main full, skid empty, deq & acc: beat -> main (replace).
  - main full, skid empty, deq & !acc: main_valid<=0.
  - main full, skid empty, !deq & acc: beat -> skid; in_ready falls next cycle.
  - main full, skid full, deq: skid -> main, skid_valid<=0. No acc is possible here because in_ready=0.
  - main full, skid full, !deq: hold everything.
- in_ready is driven only from the skid_valid flop. There is no combinational out_ready -> in_ready path.
- Output data is stable while out_valid=1 and out_ready=0. The held beat must not change until deq.
- Control outputs are zero whenever out_valid=0, so a bubble never writes back or accesses memory. Data outputs may hold stale values in that case.
- flush=1 at an edge:
  - main_valid<=0, skid_valid<=0, and the stored control bits are cleared.
  - Any concurrent acc beat is dropped.
  - flush has priority over acc and deq. A concurrent deq still counts as consumed by MEM that cycle.
- occupancy = main_valid + skid_valid.
- Beats leave in strict arrival order. None are dropped or duplicated except on flush.
- Reset asserted mid-transfer: state clears immediately and asynchronously. The first accepted beat after release goes to main.

Test Plan:
- Reset, then in_valid=1 for 3 cycles with ALU_result_in=0x11,0x22,0x33 and Dest_in=1,2,3, out_ready=1 -> outputs 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept; occupancy stays at 1.
- out_ready=0, push 0xA (WB_en=1, Dest=5) then 0xB -> occupancy=2, in_ready=0 after the second accept. Output holds 0xA with fwd_valid=1 and fwd_dest=5. in_valid with 0xC is not accepted.
- Continue from the full state, raise out_ready=1 -> 0xA then 0xB drain on successive cycles; in_ready returns to 1 one cycle after the first deq. Then 0xC is accepted and follows 0xB.
- Full state plus flush=1 together with in_valid=1 -> next cycle out_valid=0, occupancy=0, WB_en_out=MEM_R_EN_out=MEM_W_EN_out=0, in_ready=1. The flushed beat never appears.
- Assert rst asynchronously mid-cycle while occupancy=2 -> outputs go to 0 before the next edge. After release, beat 0x55 appears alone.
- Random in_valid/out_ready for 10k cycles against a scoreboard FIFO:
  - order and data are preserved.
  - control outputs are 0 whenever out_valid=0.
  - held outputs are stable under backpressure.
  - occupancy never exceeds 2.
